spe_multi_neuron: RTL and testbench

//  Parametrised clocked Sum PE. Aggregates NUM_PSUMS partial sums per output neuron and

---
 rtl/spe_multi_neuron.sv | 145 ++++++++++++++
 tb/tb_spe_multi_neuron.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spe_multi_neuron.sv
// Sum PE: accumulates NUM_PSUMS partial sums per neuron, applies leak/threshold to a local potential, emits one packet per group.
// Latency: last PSUM accepted at edge N gives out_valid after edge N+2. While a packet waits for out_ready, in_ready is low and nothing is accepted.
module spe_multi_neuron #(
    parameter int PE_ID       = 0,
    parameter int OMEM_ID     = 10,
    parameter int NUM_PSUMS   = 5,
    parameter int NUM_NEURONS = 21,
    parameter int IDX_W       = 5,
    parameter int SUM_W       = 13,
    parameter int THRESHOLD   = 64,
    parameter int LEAK        = 0,
    parameter int RESET_MODE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  timestep,
    output logic        err
);
    localparam int CNT_W = $clog2(NUM_PSUMS + 1);
    localparam int PAD_W = 25 - (SUM_W + 1 + IDX_W);
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;
    localparam logic [SUM_W-1:0] THR_V    = SUM_W'(THRESHOLD);
    localparam logic [SUM_W-1:0] LEAK_V   = SUM_W'(LEAK);
    localparam logic [IDX_W:0]   NN_V     = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PSUMS - 1);

    typedef enum logic [1:0] {RECV, UPDATE, SEND} state_t;

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] grp_idx;
    logic [SUM_W-1:0] pot [NUM_NEURONS];

    logic [3:0]       op;
    logic [SUM_W-1:0] psum;
    logic [IDX_W-1:0] idx;
    logic             unused_bits;

    assign op          = in_data[28:25];
    assign psum        = in_data[SUM_W-1:0];
    assign idx         = in_data[SUM_W +: IDX_W];
    assign unused_bits = ^{in_data[32:29], in_data[24:SUM_W+IDX_W]};

    logic [SUM_W:0]   acc_sum;
    logic [SUM_W-1:0] acc_sat;
    logic [SUM_W:0]   pot_sum;
    logic [SUM_W-1:0] p_sat;
    logic [SUM_W-1:0] p_leak;
    logic [SUM_W-1:0] p_new;
    logic             spike;
    logic [32:0]      pkt;

    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, psum};
        acc_sat = acc_sum[SUM_W] ? SUM_MAX : acc_sum[SUM_W-1:0];
        pot_sum = {1'b0, pot[grp_idx]} + {1'b0, acc};
        p_sat   = pot_sum[SUM_W] ? SUM_MAX : pot_sum[SUM_W-1:0];
        p_leak  = (p_sat > LEAK_V) ? (p_sat - LEAK_V) : '0;
        spike   = (p_leak > THR_V);
        p_new   = p_leak;
        if (spike) begin
            p_new = (RESET_MODE != 0) ? '0 : (p_leak - THR_V);
        end
        pkt = {4'(OMEM_ID), 1'b1, 3'(PE_ID), {PAD_W{1'b0}}, grp_idx, p_new, spike};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RECV;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            timestep  <= '0;
            err       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            grp_idx   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                RECV: begin
                    if (in_valid && in_ready) begin
                        case (op)
                            4'd0: begin
                                if ({1'b0, idx} >= NN_V) begin
                                    err <= 1'b1;
                                end else if (cnt != '0 && idx != grp_idx) begin
                                    err <= 1'b1;
                                    acc <= '0;
                                    cnt <= '0;
                                end else begin
                                    if (cnt == '0) grp_idx <= idx;
                                    acc <= acc_sat;
                                    cnt <= cnt + 1'b1;
                                    if (cnt == LAST_CNT) begin
                                        state    <= UPDATE;
                                        in_ready <= 1'b0;
                                    end
                                end
                            end
                            4'd1: begin
                                timestep <= timestep + 8'd1;
                                if (cnt != '0) begin
                                    err <= 1'b1;
                                    acc <= '0;
                                    cnt <= '0;
                                end
                            end
                            4'd2: begin
                                for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                UPDATE: begin
                    pot[grp_idx] <= p_new;
                    out_data     <= pkt;
                    acc          <= '0;
                    cnt          <= '0;
                    state        <= SEND;
                end
                SEND: begin
                    // Valid is raised one cycle after the packet is registered, so it is stable before offered.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= RECV;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_spe_multi_neuron.sv
// Directed bench for spe_multi_neuron; a second instance with RESET_MODE=1 shares all inputs.
module tb_spe_multi_neuron;
    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] in_data;
    logic        in_valid;
    logic        in_ready, in_ready1;
    logic [32:0] out_data, out_data1;
    logic        out_valid, out_valid1;
    logic        out_ready;
    logic [7:0]  timestep, timestep1;
    logic        err, err1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spe_multi_neuron u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .timestep(timestep), .err(err)
    );

    spe_multi_neuron #(.RESET_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .timestep(timestep1), .err(err1)
    );

    function automatic logic [32:0] exp_pkt(input logic [4:0] i, input logic [12:0] p, input logic s);
        return {4'd10, 4'b1000, 6'd0, i, p, s};
    endfunction

    // Offers one packet and returns #1 after the accepting edge.
    task automatic put(input logic [3:0] op, input logic [4:0] i, input logic [12:0] v);
        int n = 0;
        in_data  = {4'd0, op, 7'd0, i, v};
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL put_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_pkt(output logic [32:0] d);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL get_timeout: out_valid=%b required 1", out_valid);
        end
        d = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, out_valid, out_data, timestep, err} !== {1'b1, 1'b0, 33'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b dat=%h ts=%0d err=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, timestep, err);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_latency;
        logic [32:0] d;
        for (int k = 0; k < 5; k++) put(4'd0, 5'd3, 13'd10);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: err=%b required 0", err); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_n1: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_n2: out_valid=%b required 1", out_valid); end
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd3, 13'd50, 1'b0)) begin
            n_fail++; $display("FAIL basic_pkt: got %h required %h", d, exp_pkt(5'd3, 13'd50, 1'b0));
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_handshake: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_spike;
        logic [32:0] d, d1;
        put(4'd1, 5'd0, 13'd0);
        n_checks++;
        if (timestep !== 8'd1) begin n_fail++; $display("FAIL ts_inc: got %0d required 1", timestep); end
        for (int k = 0; k < 5; k++) put(4'd0, 5'd3, 13'd4);
        d1 = 33'd0;
        while (!out_valid) begin @(posedge clk); #1; end
        d1 = out_data1;
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd3, 13'd6, 1'b1)) begin
            n_fail++; $display("FAIL spike_sub: got %h required %h", d, exp_pkt(5'd3, 13'd6, 1'b1));
        end
        n_checks++;
        if (d1 !== exp_pkt(5'd3, 13'd0, 1'b1)) begin
            n_fail++; $display("FAIL spike_zero: got %h required %h", d1, exp_pkt(5'd3, 13'd0, 1'b1));
        end
    endtask

    task automatic test_backpressure;
        logic [32:0] d;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) put(4'd0, 5'd5, 13'd1);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_pkt(5'd5, 13'd5, 1'b0)) begin
            n_fail++; $display("FAIL stall_pkt: vld=%b got %h required 1 %h", out_valid, out_data, exp_pkt(5'd5, 13'd5, 1'b0));
        end
        in_data  = {4'd0, 4'd0, 7'd0, 5'd6, 13'd2};
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_data !== exp_pkt(5'd5, 13'd5, 1'b0) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: dat=%h vld=%b rdy=%b required %h 1 0", out_data, out_valid, in_ready, exp_pkt(5'd5, 13'd5, 1'b0));
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) put(4'd0, 5'd6, 13'd2);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd6, 13'd10, 1'b0)) begin
            n_fail++; $display("FAIL stall_next: got %h required %h", d, exp_pkt(5'd6, 13'd10, 1'b0));
        end
    endtask

    task automatic test_saturation;
        logic [32:0] d;
        for (int k = 0; k < 5; k++) put(4'd0, 5'd0, 13'd8191);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd0, 13'd8127, 1'b1)) begin
            n_fail++; $display("FAIL sat_acc: got %h required %h", d, exp_pkt(5'd0, 13'd8127, 1'b1));
        end
        for (int k = 0; k < 5; k++) put(4'd0, 5'd0, 13'd8191);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd0, 13'd8127, 1'b1)) begin
            n_fail++; $display("FAIL sat_pot: got %h required %h", d, exp_pkt(5'd0, 13'd8127, 1'b1));
        end
    endtask

    task automatic test_errors;
        logic [32:0] d;
        put(4'd0, 5'd1, 13'd1);
        put(4'd0, 5'd1, 13'd1);
        put(4'd0, 5'd2, 13'd1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_mismatch: err=%b required 1", err); end
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: err=%b required 0", err); end
        put(4'd0, 5'd25, 13'd1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_idx: err=%b required 1", err); end
        put(4'd7, 5'd0, 13'd0);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_opcode: err=%b required 1", err); end
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_output: out_valid=%b required 0", out_valid); end
        for (int k = 0; k < 5; k++) put(4'd0, 5'd1, 13'd3);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd1, 13'd15, 1'b0)) begin
            n_fail++; $display("FAIL err_recover: got %h required %h", d, exp_pkt(5'd1, 13'd15, 1'b0));
        end
        put(4'd0, 5'd4, 13'd1);
        put(4'd1, 5'd0, 13'd0);
        n_checks++;
        if (err !== 1'b1 || timestep !== 8'd2) begin
            n_fail++; $display("FAIL ts_partial: err=%b ts=%0d required 1 2", err, timestep);
        end
        for (int k = 0; k < 5; k++) put(4'd0, 5'd4, 13'd1);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd4, 13'd5, 1'b0)) begin
            n_fail++; $display("FAIL ts_discard: got %h required %h", d, exp_pkt(5'd4, 13'd5, 1'b0));
        end
    endtask

    task automatic test_clear;
        logic [32:0] d;
        put(4'd2, 5'd0, 13'd0);
        n_checks++;
        if (err !== 1'b0 || timestep !== 8'd2) begin
            n_fail++; $display("FAIL clear_side: err=%b ts=%0d required 0 2", err, timestep);
        end
        for (int k = 0; k < 5; k++) put(4'd0, 5'd3, 13'd10);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd3, 13'd50, 1'b0)) begin
            n_fail++; $display("FAIL clear_pot: got %h required %h", d, exp_pkt(5'd3, 13'd50, 1'b0));
        end
    endtask

    task automatic test_reset_mid_group;
        logic [32:0] d;
        for (int k = 0; k < 3; k++) put(4'd0, 5'd3, 13'd10);
        reset = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, out_valid, out_data, timestep, err} !== {1'b1, 1'b0, 33'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b vld=%b dat=%h ts=%0d err=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, timestep, err);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) put(4'd0, 5'd3, 13'd10);
        get_pkt(d);
        n_checks++;
        if (d !== exp_pkt(5'd3, 13'd50, 1'b0)) begin
            n_fail++; $display("FAIL reset_fresh: got %h required %h", d, exp_pkt(5'd3, 13'd50, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_spike();
        test_backpressure();
        test_saturation();
        test_errors();
        test_clear();
        test_reset_mid_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
